// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands, CHUNK bits per clock LSB-first, registered ripple carry.
// Optional macro ADD_SUB_SAT_EN enables signed saturation of S on overflow at completion.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       dbg_state_o
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] result;
  logic             ovf_w;
  int               base;

  // b_q holds B' (already inverted for subtract) so RUN is always a plain add.
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    a_slice   = a_q[base +: CHUNK];
    b_slice   = b_q[base +: CHUNK];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    acc_step  = acc_q;
    acc_step[base +: CHUNK] = slice_sum[CHUNK-1:0];
    ovf_w     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_step[WIDTH-1] != a_q[WIDTH-1]);
    result    = acc_step;
`ifdef ADD_SUB_SAT_EN
    if (ovf_w) begin
      result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          a_d     = A;
          b_d     = Op ? ~B : B;
          carry_d = Op ? ~Cin : Cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_step;
        carry_d = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          s_d     = result;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = ovf_w;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy        = (state_q == ST_RUN);
  assign Done        = (state_q == ST_DONE);
  assign S           = s_q;
  assign Cout        = cout_q;
  assign Ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three configurations (8/1, 8/4, 16/2) checked against an integer-arithmetic model.
// Operands are applied on the falling edge; outputs are sampled on the falling edge.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, op, cin;
  logic [15:0] a_bus, b_bus;

  logic       busy0, done0, cout0, ovf0;
  logic [7:0] s0;
  logic [1:0] st0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] s1;
  logic [1:0] st1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] s2;
  logic [1:0]  st2;

  serial_add_sub #(.WIDTH(8), .CHUNK(1)) u_dut0 (
    .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a_bus[7:0]), .B(b_bus[7:0]), .Cin(cin),
    .Busy(busy0), .Done(done0), .S(s0), .Cout(cout0), .Ovf(ovf0), .dbg_state_o(st0));

  serial_add_sub #(.WIDTH(8), .CHUNK(4)) u_dut1 (
    .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a_bus[7:0]), .B(b_bus[7:0]), .Cin(cin),
    .Busy(busy1), .Done(done1), .S(s1), .Cout(cout1), .Ovf(ovf1), .dbg_state_o(st1));

  serial_add_sub #(.WIDTH(16), .CHUNK(2)) u_dut2 (
    .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a_bus), .B(b_bus), .Cin(cin),
    .Busy(busy2), .Done(done2), .S(s2), .Cout(cout2), .Ovf(ovf2), .dbg_state_o(st2));

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];

  // Reference: true unsigned and signed results of A+B+Cin or A-B-Cin at width w.
  function automatic void model(input int w, input bit op_m, input logic [15:0] a_m, input logic [15:0] b_m,
                                input bit cin_m, output logic [15:0] s_m, output bit cout_m, output bit ovf_m);
    longint md, half, ua, ub, sa, sb, full, sres, c;
    md   = longint'(1) << w;
    half = md / 2;
    c    = longint'(cin_m);
    ua   = longint'(a_m) % md;
    ub   = longint'(b_m) % md;
    sa   = (ua >= half) ? ua - md : ua;
    sb   = (ub >= half) ? ub - md : ub;
    full = op_m ? ua - ub - c : ua + ub + c;
    sres = op_m ? sa - sb - c : sa + sb + c;
    cout_m = op_m ? (full >= 0) : (full >= md);
    ovf_m  = (sres >= half) || (sres < -half);
    s_m    = 16'(((full % md) + md) % md);
`ifdef ADD_SUB_SAT_EN
    if (ovf_m) s_m = (sa < 0) ? 16'(half) : 16'(half - 1);
`endif
  endfunction

  // Called at a falling edge; Start is sampled at the next rising edge, then inputs are scrambled.
  task automatic launch(input bit op_i, input logic [15:0] a_i, input logic [15:0] b_i, input bit cin_i);
    op = op_i; a_bus = a_i; b_bus = b_i; cin = cin_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_bus = 16'($urandom); b_bus = 16'($urandom); op = 1'($urandom); cin = 1'($urandom);
  endtask

  // Observes dut0 until Done (bounded); returns with time at the Done cycle's falling edge.
  task automatic run_to_done(input int skip, output bit seen, output int cnt, output bit overlap);
    seen = 1'b0; cnt = skip; overlap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy0 && done0) overlap = 1'b1;
      if (done0) begin
        seen = 1'b1;
        break;
      end
      if (busy0) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; a_bus = '0; b_bus = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy0, done0, s0, cout0, ovf0} !== 12'd0)
      $display("FAIL reset_outputs: busy=%b done=%b s=%h cout=%b ovf=%b, want all 0", busy0, done0, s0, cout0, ovf0);
    else n_pass++;
    n_checks++;
    if ({busy2, done2, s2} !== 18'd0) $display("FAIL reset_w16: busy=%b done=%b s=%h, want 0", busy2, done2, s2);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [15:0] es; bit ec, eo, seen, ovl; int cnt;
    model(8, 1'b0, 16'h3C, 16'h45, 1'b0, es, ec, eo);
    launch(1'b0, 16'h3C, 16'h45, 1'b0);
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen) $display("FAIL add_done: no Done within budget, want Done");
    else n_pass++;
    n_checks++;
    if (cnt != 8) $display("FAIL add_busy_len: busy cycles=%0d, want 8", cnt);
    else n_pass++;
    n_checks++;
    if (ovl) $display("FAIL add_busy_done_overlap: Busy and Done high together, want never");
    else n_pass++;
    n_checks++;
    if ({ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL add_result: s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_sub();
    logic [15:0] es; bit ec, eo, seen, ovl; int cnt;
    model(8, 1'b1, 16'h10, 16'h20, 1'b0, es, ec, eo);
    launch(1'b1, 16'h10, 16'h20, 1'b0);
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL sub_borrow: seen=%b s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", seen, s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    model(8, 1'b1, 16'h20, 16'h10, 1'b1, es, ec, eo);
    launch(1'b1, 16'h20, 16'h10, 1'b1);
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL sub_bin: seen=%b s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", seen, s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_carry_wrap_hold();
    logic [15:0] es; bit ec, eo, seen, ovl; int cnt;
    model(8, 1'b0, 16'hFF, 16'h01, 1'b0, es, ec, eo);
    launch(1'b0, 16'hFF, 16'h01, 1'b0);
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL carry_wrap: seen=%b s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", seen, s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done0, busy0, cout0, s0} !== {1'b0, 1'b0, ec, es[7:0]})
      $display("FAIL result_hold: done=%b busy=%b s=%h cout=%b, want done=0 busy=0 s=%h cout=%b", done0, busy0, s0, cout0, es[7:0], ec);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [15:0] es; bit ec, eo, seen, ovl; int cnt;
    model(8, 1'b0, 16'h12, 16'h34, 1'b1, es, ec, eo);
    launch(1'b0, 16'h12, 16'h34, 1'b1);
    @(negedge clk);
    op = 1'b1; a_bus = 16'h55; b_bus = 16'h66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(2, seen, cnt, ovl);
    n_checks++;
    if (cnt != 8) $display("FAIL midrun_start_len: busy cycles=%0d, want 8", cnt);
    else n_pass++;
    n_checks++;
    if (!seen || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL midrun_start_result: seen=%b s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", seen, s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] es; bit ec, eo, seen, ovl; int cnt;
    launch(1'b0, 16'h01, 16'h02, 1'b0);
    run_to_done(0, seen, cnt, ovl);
    model(8, 1'b1, 16'h05, 16'h09, 1'b0, es, ec, eo);
    launch(1'b1, 16'h05, 16'h09, 1'b0);
    n_checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) $display("FAIL b2b_busy_rise: busy=%b done=%b, want busy=1 done=0", busy0, done0);
    else n_pass++;
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen || cnt != 8 || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL b2b_result: seen=%b cnt=%0d s=%h cout=%b ovf=%b, want cnt=8 s=%h cout=%b ovf=%b",
               seen, cnt, s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rst_midrun();
    bit got;
    launch(1'b0, 16'h40, 16'h41, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy0, done0, s0, cout0, ovf0} !== 12'd0)
      $display("FAIL rst_midrun: busy=%b done=%b s=%h cout=%b ovf=%b, want all 0", busy0, done0, s0, cout0, ovf0);
    else n_pass++;
    got = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done0 || busy0) got = 1'b1;
    end
    n_checks++;
    if (got) $display("FAIL rst_no_late_done: saw Busy/Done after reset, want none");
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [15:0] es; bit ec, eo, seen, ovl; int cnt;
    model(8, 1'b0, 16'h7F, 16'h01, 1'b0, es, ec, eo);
    launch(1'b0, 16'h7F, 16'h01, 1'b0);
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL pos_ovf: s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    model(8, 1'b1, 16'h80, 16'h01, 1'b0, es, ec, eo);
    launch(1'b1, 16'h80, 16'h01, 1'b0);
    run_to_done(0, seen, cnt, ovl);
    n_checks++;
    if (!seen || {ovf0, cout0, s0} !== {eo, ec, es[7:0]})
      $display("FAIL neg_ovf: s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s0, cout0, ovf0, es[7:0], ec, eo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] es, ra, rb; bit ec, eo, rop, rcin, seen, ovl; int cnt;
    logic [9:0] exp;
    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom); rcin = 1'($urandom);
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      model(8, rop, ra, rb, rcin, es, ec, eo);
      exp_q.push_back({eo, ec, es[7:0]});
      launch(rop, ra, rb, rcin);
      run_to_done(0, seen, cnt, ovl);
      exp = exp_q.pop_front();
      n_checks++;
      if (!seen || cnt != 8 || ovl || {ovf0, cout0, s0} !== exp)
        $display("FAIL random_%0d: op=%b a=%h b=%h cin=%b seen=%b cnt=%0d got {ovf,cout,s}=%h want %h",
                 i, rop, ra[7:0], rb[7:0], rcin, seen, cnt, {ovf0, cout0, s0}, exp);
      else n_pass++;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // dut1 (8-bit, 4 per clock) and dut2 (16-bit, 2 per clock) run side by side on the same operands.
  task automatic test_chunk_cfg(input string name, input bit op_i, input logic [15:0] a_i, input logic [15:0] b_i, input bit cin_i);
    logic [15:0] es1, es2; bit ec1, eo1, ec2, eo2;
    int c1, c2; bit d1, d2;
    model(8, op_i, a_i, b_i, cin_i, es1, ec1, eo1);
    model(16, op_i, a_i, b_i, cin_i, es2, ec2, eo2);
    c1 = 0; c2 = 0; d1 = 1'b0; d2 = 1'b0;
    launch(op_i, a_i, b_i, cin_i);
    for (int k = 0; k < 20 && !(d1 && d2); k++) begin
      if (!d1) begin
        if (done1) begin
          d1 = 1'b1;
          n_checks++;
          if (c1 != 2 || {ovf1, cout1, s1} !== {eo1, ec1, es1[7:0]})
            $display("FAIL %s_w8c4: cnt=%0d s=%h cout=%b ovf=%b, want cnt=2 s=%h cout=%b ovf=%b",
                     name, c1, s1, cout1, ovf1, es1[7:0], ec1, eo1);
          else n_pass++;
        end else if (busy1) c1++;
      end
      if (!d2) begin
        if (done2) begin
          d2 = 1'b1;
          n_checks++;
          if (c2 != 8 || {ovf2, cout2, s2} !== {eo2, ec2, es2})
            $display("FAIL %s_w16c2: cnt=%0d s=%h cout=%b ovf=%b, want cnt=8 s=%h cout=%b ovf=%b",
                     name, c2, s2, cout2, ovf2, es2, ec2, eo2);
          else n_pass++;
        end else if (busy2) c2++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!(d1 && d2)) $display("FAIL %s_timeout: done8=%b done16=%b, want both", name, d1, d2);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_wrap_hold();
    test_start_ignored();
    test_back_to_back();
    test_rst_midrun();
    test_saturation();
    test_random();
    test_chunk_cfg("cfg_add", 1'b0, 16'h003C, 16'h0045, 1'b0);
    test_chunk_cfg("cfg_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 6; i++)
      test_chunk_cfg("cfg_rand", 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
